// File: rtl/mm_feeder.sv
// Tile feeder for a matrix-vector array: loads a vector and a matrix, issues them, then drains the result.
// Define MM_FEEDER_TIMEOUT_EN to abandon a tile when the array result does not arrive within TIMEOUT cycles.
module mm_feeder #(
    parameter int M       = 16,
    parameter int N       = 16,
    parameter int DW      = 32,
    parameter int LANES   = 4,
    parameter int TIMEOUT = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DW*LANES-1:0]   in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [DW*N*M-1:0]     matrix_input,
    output logic [DW*N-1:0]       vector_input,
    output logic                  input_valid,
    input  logic [DW*N-1:0]       vector_output,
    input  logic                  add_valid,
    output logic [DW*LANES-1:0]   out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last,
    output logic                  busy,
    output logic                  err_timeout
);
    localparam int VB = N / LANES;
    localparam int MB = M * N / LANES;
    localparam int CW = $clog2(MB);
    localparam int VW = (VB > 1) ? $clog2(VB) : 1;

    typedef enum logic [2:0] {LOAD_VEC, LOAD_MAT, ISSUE, WAIT, DRAIN} state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       beat_q, beat_d;
    logic [DW*N-1:0]     vec_q, vec_d;
    logic [DW*N-1:0]     res_q, res_d;
    logic [DW*N*M-1:0]   mat_q, mat_d;
    logic                in_ready_q, in_ready_d;
    logic                input_valid_q, input_valid_d;
    logic                out_valid_q, out_valid_d;
    logic                out_last_q, out_last_d;
    logic                busy_q, busy_d;
    logic                timeout_hit;
`ifdef MM_FEEDER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT);
    logic [TW-1:0]       wait_q, wait_d;
`endif

    // NOTE: every next-state signal gets its default first, so the blocking assigns below cannot infer latches.
    always_comb begin
        state_d     = state_q;
        beat_d      = beat_q;
        vec_d       = vec_q;
        mat_d       = mat_q;
        res_d       = res_q;
        timeout_hit = 1'b0;
`ifdef MM_FEEDER_TIMEOUT_EN
        wait_d      = wait_q;
`endif
        case (state_q)
            LOAD_VEC: begin
                if (in_valid) begin
                    for (int j = 0; j < LANES; j++) begin
                        vec_d[(int'(beat_q[VW-1:0]) * LANES + j) * DW +: DW] = in_data[j*DW +: DW];
                    end
                    if (beat_q == CW'(VB - 1)) begin
                        beat_d  = '0;
                        state_d = LOAD_MAT;
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end
            end
            LOAD_MAT: begin
                if (in_valid) begin
                    for (int j = 0; j < LANES; j++) begin
                        mat_d[(int'(beat_q) * LANES + j) * DW +: DW] = in_data[j*DW +: DW];
                    end
                    if (beat_q == CW'(MB - 1)) begin
                        beat_d  = '0;
                        state_d = ISSUE;
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end
            end
            ISSUE: state_d = WAIT;
            WAIT: begin
                // A result arriving on the expiry cycle takes priority over the timeout.
                if (add_valid) begin
                    res_d   = vector_output;
                    state_d = DRAIN;
`ifdef MM_FEEDER_TIMEOUT_EN
                    wait_d  = '0;
                end else if (wait_q == TW'(TIMEOUT - 1)) begin
                    timeout_hit = 1'b1;
                    wait_d      = '0;
                    state_d     = LOAD_VEC;
                end else begin
                    wait_d = wait_q + 1'b1;
`endif
                end
            end
            DRAIN: begin
                if (out_ready) begin
                    if (beat_q == CW'(VB - 1)) begin
                        beat_d  = '0;
                        state_d = LOAD_VEC;
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end
            end
            default: begin
                beat_d  = '0;
                state_d = LOAD_VEC;
            end
        endcase

        // Handshake outputs are registered from the next state so they never glitch.
        in_ready_d    = (state_d == LOAD_VEC) || (state_d == LOAD_MAT);
        input_valid_d = (state_d == ISSUE);
        out_valid_d   = (state_d == DRAIN);
        out_last_d    = (state_d == DRAIN) && (beat_d == CW'(VB - 1));
        busy_d        = !((state_d == LOAD_VEC) && (beat_d == '0));
    end

    // NOTE: the data buffers are cleared on reset because they drive the array ports directly.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= LOAD_VEC;
            beat_q        <= '0;
            vec_q         <= '0;
            mat_q         <= '0;
            res_q         <= '0;
            in_ready_q    <= 1'b1;
            input_valid_q <= 1'b0;
            out_valid_q   <= 1'b0;
            out_last_q    <= 1'b0;
            busy_q        <= 1'b0;
`ifdef MM_FEEDER_TIMEOUT_EN
            wait_q        <= '0;
`endif
        end else begin
            state_q       <= state_d;
            beat_q        <= beat_d;
            vec_q         <= vec_d;
            mat_q         <= mat_d;
            res_q         <= res_d;
            in_ready_q    <= in_ready_d;
            input_valid_q <= input_valid_d;
            out_valid_q   <= out_valid_d;
            out_last_q    <= out_last_d;
            busy_q        <= busy_d;
`ifdef MM_FEEDER_TIMEOUT_EN
            wait_q        <= wait_d;
`endif
        end
    end

    assign in_ready     = in_ready_q;
    assign input_valid  = input_valid_q;
    assign out_valid    = out_valid_q;
    assign out_last     = out_last_q;
    assign busy         = busy_q;
    assign matrix_input = mat_q;
    assign vector_input = vec_q;
    assign out_data     = res_q[int'(beat_q[VW-1:0]) * (LANES*DW) +: LANES*DW];
    assign err_timeout  = timeout_hit;

endmodule

// File: tb/tb_mm_feeder.sv
// Randomized bench for mm_feeder: a word-array model of the tile drives the feeder, plays the array,
// and scores issued buffers, drained beats and the optional timeout against the model.
module tb_mm_feeder;
    localparam int M       = 16;
    localparam int N       = 16;
    localparam int DW      = 32;
    localparam int LANES   = 4;
    localparam int TIMEOUT = 1024;
    localparam int VB      = N / LANES;
    localparam int MB      = M * N / LANES;
`ifdef MM_FEEDER_TIMEOUT_EN
    localparam int EXP_ERR = 1;
`else
    localparam int EXP_ERR = 0;
`endif

    logic                 clk;
    logic                 rst;
    logic [DW*LANES-1:0]  in_data;
    logic                 in_valid;
    logic                 in_ready;
    logic [DW*N*M-1:0]    matrix_input;
    logic [DW*N-1:0]      vector_input;
    logic                 input_valid;
    logic [DW*N-1:0]      vector_output;
    logic                 add_valid;
    logic [DW*LANES-1:0]  out_data;
    logic                 out_valid;
    logic                 out_ready;
    logic                 out_last;
    logic                 busy;
    logic                 err_timeout;

    mm_feeder #(.M(M), .N(N), .DW(DW), .LANES(LANES), .TIMEOUT(TIMEOUT)) dut (
        .clk           (clk),
        .rst           (rst),
        .in_data       (in_data),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .matrix_input  (matrix_input),
        .vector_input  (vector_input),
        .input_valid   (input_valid),
        .vector_output (vector_output),
        .add_valid     (add_valid),
        .out_data      (out_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_last      (out_last),
        .busy          (busy),
        .err_timeout   (err_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int                  n_checks;
    int                  n_errors;
    int                  iv_count;
    int                  iv_exp;
    int                  err_cnt;
    logic [DW*LANES-1:0] got_data[$];
    logic                got_last[$];
    logic                hold_pending;
    logic [DW*LANES-1:0] hold_data;
    logic [31:0]         vec_m[N];
    logic [31:0]         mat_m[M*N];
    logic [31:0]         res_m[N];
    bit                  tog;

    task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Packs cnt consecutive model words (sel: 0 vector, 1 matrix, 2 result) starting at base, word 0 lowest.
    function automatic logic [511:0] pack_words(input int sel, input int base, input int cnt);
        logic [511:0] r;
        r = '0;
        for (int i = 0; i < cnt; i++) begin
            case (sel)
                0:       r[i*DW +: DW] = vec_m[base+i];
                1:       r[i*DW +: DW] = mat_m[base+i];
                default: r[i*DW +: DW] = res_m[base+i];
            endcase
        end
        return r;
    endfunction

    task automatic fill_random();
        for (int i = 0; i < N; i++) vec_m[i] = $urandom;
        for (int i = 0; i < M*N; i++) mat_m[i] = $urandom;
        for (int i = 0; i < N; i++) res_m[i] = $urandom;
    endtask

    // Output-side monitor: collects transferred beats, counts pulses, checks stall stability.
    always @(negedge clk) begin
        if (input_valid) iv_count++;
        if (err_timeout) err_cnt++;
        if (hold_pending) begin
            check("out_hold_data", out_data, hold_data);
            check("out_hold_valid", out_valid, 1);
        end
        hold_pending = out_valid && !out_ready;
        hold_data    = out_data;
        if (out_valid && out_ready) begin
            got_data.push_back(out_data);
            got_last.push_back(out_last);
        end
    end

    task automatic check_idle(input string tag);
        check({tag, "_in_ready"}, in_ready, 1);
        check({tag, "_input_valid"}, input_valid, 0);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_out_last"}, out_last, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_err"}, err_timeout, 0);
        check({tag, "_vec"}, vector_input, 0);
        check({tag, "_mat_zero"}, matrix_input == '0, 1);
        check({tag, "_out_data"}, out_data, 0);
    endtask

    // mode 0: back-to-back, 1: valid toggles every cycle, 2: random gaps
    task automatic feed(input bit is_mat, input int nbeats, input int mode);
        int k = 0;
        int budget = nbeats * 4 + 20;
        bit v;
        bit rdy;
        logic [511:0] w;
        while (k < nbeats && budget > 0) begin
            case (mode)
                0: v = 1'b1;
                1: begin v = tog; tog = !tog; end
                default: v = ($urandom_range(0, 3) != 0);
            endcase
            w = pack_words(is_mat ? 1 : 0, k * LANES, LANES);
            in_data  = v ? w[DW*LANES-1:0] : {$urandom, $urandom, $urandom, $urandom};
            in_valid = v;
            rdy = in_ready;
            step();
            if (v && rdy) k++;
            budget--;
        end
        in_valid = 1'b0;
        if (k != nbeats) check(is_mat ? "feed_mat_stall" : "feed_vec_stall", k, nbeats);
    endtask

    task automatic drain(input int dmode);
        int stall_left = 5;
        int budget = 60;
        logic [511:0] e;
        check("drain_valid", out_valid, 1);
        while (got_data.size() < VB && budget > 0) begin
            case (dmode)
                0: out_ready = 1'b1;
                1: begin
                    if (got_data.size() == 1 && stall_left > 0) begin
                        out_ready = 1'b0;
                        stall_left--;
                    end else begin
                        out_ready = 1'b1;
                    end
                end
                default: begin
                    out_ready     = ($urandom_range(0, 2) != 0);
                    add_valid     = $urandom_range(0, 1);
                    vector_output = {16{$urandom}};
                end
            endcase
            step();
            budget--;
        end
        out_ready = 1'b1;
        add_valid = 1'b0;
        check("drain_beats", got_data.size(), VB);
        check("after_drain_in_ready", in_ready, 1);
        check("after_drain_out_valid", out_valid, 0);
        for (int k = 0; k < VB && got_data.size() > 0; k++) begin
            e = pack_words(2, k * LANES, LANES);
            check("out_data", got_data.pop_front(), e);
            check("out_last", got_last.pop_front(), k == VB - 1);
        end
        got_data.delete();
        got_last.delete();
    endtask

    // delay < 0 means the array never answers (timeout build only)
    task automatic run_tile(input int fmode, input int delay, input int dmode);
        int lat = 0;
        bit ok;
        if (fmode == 2) begin
            add_valid     = 1'b1;
            vector_output = {16{$urandom}};
            step();
            add_valid = 1'b0;
        end
        feed(0, VB, fmode);
        feed(1, MB, fmode);
        while (!input_valid && lat < 8) begin
            step();
            lat++;
        end
        check("issue_latency", lat, 0);
        if (!input_valid) return;
        check("issue_vec", vector_input, pack_words(0, 0, N));
        for (int c = 0; c < M; c++) check("issue_mat_col", matrix_input[c*DW*N +: DW*N], pack_words(1, c*N, N));
        check("issue_busy", busy, 1);
        check("issue_in_ready", in_ready, 0);
        iv_exp++;
        if (delay >= 0) begin
            repeat (delay) step();
            add_valid     = 1'b1;
            vector_output = pack_words(2, 0, N);
            #1;
            check("add_no_err", err_timeout, 0);
            step();
            add_valid     = 1'b0;
            vector_output = {16{$urandom}};
            drain(dmode);
        end
`ifdef MM_FEEDER_TIMEOUT_EN
        else begin
            repeat (TIMEOUT) step();
            check("err_pulse", err_timeout, 1);
            check("err_in_ready", in_ready, 0);
            step();
            check("err_clear", err_timeout, 0);
            check("err_in_ready_next", in_ready, 1);
            check("err_no_drain", out_valid, 0);
            repeat (5) step();
            check("err_no_beats", got_data.size(), 0);
        end
`endif
        check("iv_pulses", iv_count, iv_exp);
        check("hold_vec", vector_input, pack_words(0, 0, N));
        ok = 1'b1;
        for (int c = 0; c < M; c++) if (matrix_input[c*DW*N +: DW*N] !== pack_words(1, c*N, N)) ok = 1'b0;
        check("hold_mat", ok, 1);
    endtask

    initial begin
        rst           = 1'b1;
        in_data       = '0;
        in_valid      = 1'b0;
        vector_output = '0;
        add_valid     = 1'b0;
        out_ready     = 1'b1;
        tog           = 1'b1;
        hold_pending  = 1'b0;
        repeat (3) step();
        rst = 1'b0;
        check_idle("reset");

        for (int i = 0; i < N; i++) vec_m[i] = 32'(i + 1);
        for (int i = 0; i < M*N; i++) mat_m[i] = 32'(i);
        for (int i = 0; i < N; i++) res_m[i] = 32'(100 + i);
        run_tile(0, 3, 0);
        run_tile(1, 3, 1);

        fill_random();
        feed(0, VB, 0);
        feed(1, 30, 0);
        check("mid_busy", busy, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_idle("mid_rst");
        repeat (3) step();
        check("mid_no_beats", got_data.size(), 0);
        check("mid_no_issue", iv_count, iv_exp);
        fill_random();
        run_tile(2, $urandom_range(1, 20), 2);

        repeat (6) begin
            fill_random();
            run_tile(2, $urandom_range(1, 20), 2);
        end

`ifdef MM_FEEDER_TIMEOUT_EN
        fill_random();
        run_tile(0, -1, 0);
        fill_random();
        run_tile(0, TIMEOUT, 0);
`else
        fill_random();
        run_tile(0, TIMEOUT + 50, 0);
`endif
        check("err_count", err_cnt, EXP_ERR);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
